// File: rtl/iq_block_framer_pkg.sv
// Shared constants and types for the IQ block framer: K-character codes,
// block geometry, FSM state encoding and the FIFO word layout.
package system_parameters;

  localparam logic [7:0] K28_7                   = 8'hFC;
  localparam int         BLOCK_SIZE              = 1024;
  localparam int         SCALING_FACTOR_BITWIDTH = 12;
  localparam logic [3:0] HEADER_K                = 4'b1000;
  localparam logic [3:0] PAYLOAD_K               = 4'b0000;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } framer_state_t;

  typedef struct packed {
    logic [3:0]  k;
    logic [31:0] d;
  } tx_word_t;

  // Header replaces the comma sample: K28.7 in the top byte, scaling factor in the low bits.
  function automatic tx_word_t make_header(input logic [SCALING_FACTOR_BITWIDTH-1:0] sf);
    tx_word_t w;
    w.k = HEADER_K;
    w.d = {K28_7, 12'h000, sf};
    return w;
  endfunction

  function automatic tx_word_t make_payload(input logic [31:0] data);
    tx_word_t w;
    w.k = PAYLOAD_K;
    w.d = data;
    return w;
  endfunction

endpackage

// File: rtl/iq_block_framer_if.sv
// Bus between the block scaler / transceiver environment and the framer.
// 'master' is the environment side, 'slave' is the framer.
interface iq_block_framer_if #(
  parameter int DATA_W = 32,
  parameter int SF_W   = 12
) ();
  import system_parameters::*;

  // Scaler side: words are sampled on every clk edge where in_valid is high; there is
  // no backpressure towards the scaler. Transceiver side: a word moves on an edge where
  // tx_valid & tx_ready; while tx_valid & !tx_ready, tx_data/tx_k hold their value and
  // tx_valid never drops without a transfer.
  logic [DATA_W-1:0] in_data;
  logic              in_comma;
  logic [SF_W-1:0]   in_scaling_factor;
  logic              in_valid;

  logic [DATA_W-1:0] tx_data;
  logic [3:0]        tx_k;
  logic              tx_valid;
  logic              tx_ready;

  logic              locked;
  logic              sync_err;
  logic              overflow;
  framer_state_t     fsmState;

  modport master (
    output in_data, in_comma, in_scaling_factor, in_valid, tx_ready,
    input  tx_data, tx_k, tx_valid, locked, sync_err, overflow, fsmState
  );

  modport slave (
    input  in_data, in_comma, in_scaling_factor, in_valid, tx_ready,
    output tx_data, tx_k, tx_valid, locked, sync_err, overflow, fsmState
  );

endinterface

// File: rtl/iq_block_framer_fifo.sv
// Generic show-ahead synchronous FIFO: popData shows the oldest entry whenever
// empty is low. A push while full is accepted only if a pop happens in the same cycle.
module iq_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/iq_block_framer.sv
// Aligns to the scaler's comma flag, swaps each comma sample for a K28.7 header
// carrying the scaling factor, and queues frames for the transceiver.
module iq_block_framer #(
  parameter int DATA_W     = 32,
  parameter int SF_W       = 12,
  parameter int BLOCK_SIZE = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  iq_block_framer_if.slave bus
);
  import system_parameters::*;

  localparam int               CNT_W     = $clog2(BLOCK_SIZE) + 1;
  localparam logic [CNT_W-1:0] BLOCK_END = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  framer_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             locked;
  logic             syncErr;
  logic             overflow;
  logic             pushValid;
  tx_word_t         pushWord;

  logic [DATA_W-1:0] inData;
  logic [SF_W-1:0]   inSf;
  tx_word_t          popWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPop;

  assign inData = bus.in_data;
  assign inSf   = bus.in_scaling_factor;

  // cnt counts words of the current block including its header; a block is
  // complete when it reaches BLOCK_END, so the missing-comma rule fires before any wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= '0;
      locked    <= 1'b0;
      syncErr   <= 1'b0;
      pushValid <= 1'b0;
      pushWord  <= '0;
    end else begin
      syncErr   <= 1'b0;
      pushValid <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          HUNT: begin
            if (bus.in_comma) begin
              pushValid <= 1'b1;
              pushWord  <= make_header(inSf);
              cnt       <= CNT_ONE;
              locked    <= 1'b1;
              state     <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (bus.in_comma) begin
              syncErr   <= (cnt != BLOCK_END);
              pushValid <= 1'b1;
              pushWord  <= make_header(inSf);
              cnt       <= CNT_ONE;
            end else if (cnt == BLOCK_END) begin
              syncErr <= 1'b1;
              locked  <= 1'b0;
              cnt     <= '0;
              state   <= HUNT;
            end else begin
              pushValid <= 1'b1;
              pushWord  <= make_payload(inData);
              cnt       <= cnt + CNT_ONE;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign fifoPop = !fifoEmpty && bus.tx_ready;

  // A push lost to a full FIFO latches overflow until reset; framing keeps counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (pushValid && fifoFull && !fifoPop) begin
      overflow <= 1'b1;
    end
  end

  iq_sync_fifo #(
    .WIDTH ($bits(tx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushValid),
    .pushData (pushWord),
    .pop      (fifoPop),
    .popData  (popWord),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign bus.tx_valid = !fifoEmpty;
  assign bus.tx_data  = fifoEmpty ? '0 : popWord.d;
  assign bus.tx_k     = fifoEmpty ? '0 : popWord.k;
  assign bus.locked   = locked;
  assign bus.sync_err = syncErr;
  assign bus.overflow = overflow;
  assign bus.fsmState = state;

endmodule

// File: tb/tb_iq_block_framer.sv
// Directed-plus-random bench for iq_block_framer with a frame-level reference model
// and a scoreboard queue of expected transceiver words.
module tb_iq_block_framer;
  import system_parameters::*;

  localparam int BLK   = 1024;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_block_framer_if #(.DATA_W(32), .SF_W(12)) bus ();

  iq_block_framer #(
    .DATA_W     (32),
    .SF_W       (12),
    .BLOCK_SIZE (BLK),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nAssert = 0;
  int nFail   = 0;
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  logic [35:0] exp_q[$];
  int          expCyc_q[$];

  bit mLocked    = 1'b0;
  int mPayload   = 0;
  bit pendSync   = 1'b0;
  bit pendLocked = 1'b0;
  bit expSync    = 1'b0;
  bit expLocked  = 1'b0;
  bit stallMode  = 1'b0;
  bit checkLat   = 1'b1;
  bit rdy        = 1'b1;
  int drops      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nAssert++;
    assert (obs === expv)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_word(input logic [35:0] w);
    if (stallMode && exp_q.size() >= DEPTH) begin
      drops++;
    end else begin
      exp_q.push_back(w);
      expCyc_q.push_back(cycleCnt);
    end
  endtask

  // Frame rules: a comma opens a block (its sample becomes the header); a full block is
  // one header plus BLK-1 payload words; anything else is a length violation.
  task automatic model(input logic [31:0] d, input bit c, input bit v, input logic [11:0] sf);
    pendSync = 1'b0;
    if (v) begin
      if (!mLocked) begin
        if (c) begin
          expect_word({4'b1000, 8'hFC, 12'h000, sf});
          mLocked  = 1'b1;
          mPayload = 0;
        end
      end else if (c) begin
        pendSync = (mPayload != BLK - 1);
        expect_word({4'b1000, 8'hFC, 12'h000, sf});
        mPayload = 0;
      end else if (mPayload == BLK - 1) begin
        pendSync = 1'b1;
        mLocked  = 1'b0;
      end else begin
        expect_word({4'b0000, d});
        mPayload++;
      end
    end
    pendLocked = mLocked;
  endtask

  task automatic step(input logic [31:0] d, input bit c, input bit v, input logic [11:0] sf);
    @(posedge clk);
    expSync   = pendSync;
    expLocked = pendLocked;
    #1;
    bus.in_data           = d;
    bus.in_comma          = c;
    bus.in_valid          = v;
    bus.in_scaling_factor = sf;
    bus.tx_ready          = rdy;
    model(d, c, v, sf);
  endtask

  task automatic idle();
    step(32'h0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic rand_payload(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit v;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      while (!v) begin
        step($urandom, 1'b0, 1'b0, 12'($urandom_range(0, 4095)));
        v = ($urandom_range(0, 3) != 0);
      end
      step($urandom, 1'b0, 1'b1, 12'($urandom_range(0, 4095)));
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle();
    idle();
    chk({"drain_", tag}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    expSync   = pendSync;
    expLocked = pendLocked;
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_comma = 1'b0;
    exp_q.delete();
    expCyc_q.delete();
    mLocked    = 1'b0;
    mPayload   = 0;
    pendSync   = 1'b0;
    pendLocked = 1'b0;
    drops      = 0;
    @(posedge clk);
    expSync   = 1'b0;
    expLocked = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_locked",   bus.locked,   0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_sync_err", bus.sync_err, 0);
  endtask

  // Scoreboard and per-cycle status checks.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sync_err", bus.sync_err, expSync);
      chk("locked",   bus.locked,   expLocked);
      if (bus.tx_valid && bus.tx_ready) begin
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [35:0] w;
          int          c0;
          w  = exp_q.pop_front();
          c0 = expCyc_q.pop_front();
          chk("tx_k",    bus.tx_k,    w[35:32]);
          chk("tx_data", bus.tx_data, w[31:0]);
          if (checkLat) chk("latency", cycleCnt - c0, 2);
        end
      end
    end
  end

  initial begin
    bus.in_data           = '0;
    bus.in_comma          = 1'b0;
    bus.in_valid          = 1'b0;
    bus.in_scaling_factor = '0;
    bus.tx_ready          = 1'b1;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_data",  bus.tx_data,  0);
    chk("reset_tx_k",     bus.tx_k,     0);
    chk("reset_overflow", bus.overflow, 0);
    chk("reset_state",    bus.fsmState == HUNT, 1);

    // Words before the first comma, plus a comma with in_valid low, are discarded
    rand_payload(20, 1'b1);
    step($urandom, 1'b1, 1'b0, 12'h123);
    rand_payload(5, 1'b0);

    // First block: header with sf 3A5 then 1023 incrementing payload words
    step(32'hDEAD_BEEF, 1'b1, 1'b1, 12'h3A5);
    for (int i = 0; i < BLK - 1; i++)
      step(32'h0001_0001 + 32'(i), 1'b0, 1'b1, 12'($urandom_range(0, 4095)));

    // Normal boundary, then a short block of 500 payload words with input gaps
    step($urandom, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    rand_payload(500, 1'b1);
    step($urandom, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));

    // Full block, then a missing comma: unlock and discard until the next comma
    rand_payload(BLK - 1, 1'b1);
    step($urandom, 1'b0, 1'b1, 12'h0);
    rand_payload(30, 1'b1);
    drain("hunt");
    @(negedge clk);
    chk("hunt_state",   bus.fsmState == PAYLOAD, mLocked);
    chk("overflow_pre", bus.overflow, drops > 0);

    // Transceiver stall with continuous input: 16 words held, the rest dropped
    rdy       = 1'b0;
    stallMode = 1'b1;
    checkLat  = 1'b0;
    step($urandom, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    rand_payload(19, 1'b0);
    repeat (3) idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      @(negedge clk);
      chk("stall_valid",  bus.tx_valid, 1);
      chk("stall_stable", bus.tx_data,  exp_q[0][31:0]);
      chk("stall_k",      bus.tx_k,     exp_q[0][35:32]);
    end
    chk("overflow_set", bus.overflow, drops > 0);
    rdy       = 1'b1;
    stallMode = 1'b0;
    drain("stall");
    checkLat = 1'b1;
    @(negedge clk);
    chk("overflow_sticky", bus.overflow, drops > 0);

    // Reset mid-payload, then re-lock on the next comma
    rand_payload(100, 1'b0);
    do_reset();
    rand_payload(10, 1'b1);
    step($urandom, 1'b1, 1'b1, 12'($urandom_range(0, 4095)));
    rand_payload(50, 1'b1);
    drain("final");
    @(negedge clk);
    chk("final_locked", bus.locked, mLocked);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
